// File: rtl/bottling_ctrl_param.sv
// Pill-bottling controller: BCD targets set by buttons, counts pill edges into bottles, handles faults.
// All state updates on the sampling edge; digit_out and beep are combinational from registers.
module bottling_ctrl_param #(
  parameter int PILL_DIGITS   = 3,
  parameter int BOTTLE_DIGITS = 2,
  parameter int BLINK_BIT     = 7,
  parameter int BEEP_BIT      = 8
) (
  input  logic                                       clk_1khz,
  input  logic                                       switch_clr,
  input  logic                                       btn_next,
  input  logic                                       btn_inc,
  input  logic                                       btn_start,
  input  logic                                       pill_pulse,
  input  logic                                       emergency_stop,
  input  logic                                       hopper_empty,
  input  logic                                       conveyor_jam,
  output logic [4*(PILL_DIGITS+BOTTLE_DIGITS)-1:0]   digit_out,
  output logic [2:0]                                 state_out,
  output logic [1:0]                                 err_code,
  output logic                                       beep
);

  localparam int N  = PILL_DIGITS + BOTTLE_DIGITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = ((BLINK_BIT > BEEP_BIT) ? BLINK_BIT : BEEP_BIT) + 1;

  typedef enum logic [2:0] {
    S_SETTING = 3'd0,
    S_RUNNING = 3'd1,
    S_PAUSED  = 3'd2,
    S_DONE    = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   cursor_q, cursor_d;
  logic [PILL_DIGITS-1:0][3:0]     pill_tgt_q, pill_tgt_d, pill_cnt_q, pill_cnt_d, pill_inc;
  logic [BOTTLE_DIGITS-1:0][3:0]   bot_tgt_q, bot_tgt_d, bot_cnt_q, bot_cnt_d, bot_inc;
  logic [1:0]                      err_q, err_d;
  logic [DW-1:0]                   div_q;
  logic                            next_prev_q, inc_prev_q, start_prev_q, pill_prev_q;
  logic                            next_p, inc_p, start_p, pill_p, tgt_ok;
  logic                            pill_c, bot_c;
  logic [N-1:0][3:0]               disp;

  assign next_p  = btn_next   & ~next_prev_q;
  assign inc_p   = btn_inc    & ~inc_prev_q;
  assign start_p = btn_start  & ~start_prev_q;
  assign pill_p  = pill_pulse & ~pill_prev_q;
  assign tgt_ok  = (pill_tgt_q != '0) && (bot_tgt_q != '0);

  always_ff @(posedge clk_1khz) begin
    if (switch_clr) begin
      state_q      <= S_SETTING;
      cursor_q     <= '0;
      pill_tgt_q   <= '0;
      pill_tgt_q[0] <= 4'd1;
      bot_tgt_q    <= '0;
      bot_tgt_q[0] <= 4'd1;
      pill_cnt_q   <= '0;
      bot_cnt_q    <= '0;
      err_q        <= 2'd0;
      div_q        <= '0;
      next_prev_q  <= 1'b1;
      inc_prev_q   <= 1'b1;
      start_prev_q <= 1'b1;
      pill_prev_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      pill_tgt_q   <= pill_tgt_d;
      bot_tgt_q    <= bot_tgt_d;
      pill_cnt_q   <= pill_cnt_d;
      bot_cnt_q    <= bot_cnt_d;
      err_q        <= err_d;
      div_q        <= div_q + DW'(1);
      next_prev_q  <= btn_next;
      inc_prev_q   <= btn_inc;
      start_prev_q <= btn_start;
      pill_prev_q  <= pill_pulse;
    end
  end

  // Ripple-carry BCD increments of both counts, used only on a pill edge in RUNNING
  always_comb begin
    pill_inc = pill_cnt_q;
    pill_c   = 1'b1;
    for (int i = 0; i < PILL_DIGITS; i++) begin
      if (pill_c) begin
        if (pill_inc[i] == 4'd9) pill_inc[i] = 4'd0;
        else begin
          pill_inc[i] = pill_inc[i] + 4'd1;
          pill_c      = 1'b0;
        end
      end
    end
    bot_inc = bot_cnt_q;
    bot_c   = 1'b1;
    for (int i = 0; i < BOTTLE_DIGITS; i++) begin
      if (bot_c) begin
        if (bot_inc[i] == 4'd9) bot_inc[i] = 4'd0;
        else begin
          bot_inc[i] = bot_inc[i] + 4'd1;
          bot_c      = 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    pill_tgt_d = pill_tgt_q;
    bot_tgt_d  = bot_tgt_q;
    pill_cnt_d = pill_cnt_q;
    bot_cnt_d  = bot_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_SETTING: begin
        // Increment targets the cursor as it was before any same-cycle advance
        if (inc_p) begin
          for (int i = 0; i < PILL_DIGITS; i++)
            if (cursor_q == CW'(i))
              pill_tgt_d[i] = (pill_tgt_q[i] == 4'd9) ? 4'd0 : pill_tgt_q[i] + 4'd1;
          for (int i = 0; i < BOTTLE_DIGITS; i++)
            if (cursor_q == CW'(PILL_DIGITS + i))
              bot_tgt_d[i] = (bot_tgt_q[i] == 4'd9) ? 4'd0 : bot_tgt_q[i] + 4'd1;
        end
        if (next_p) cursor_d = (cursor_q == CW'(N - 1)) ? '0 : cursor_q + CW'(1);
        if (start_p && tgt_ok) begin
          state_d    = S_RUNNING;
          pill_cnt_d = '0;
          bot_cnt_d  = '0;
        end
      end
      S_RUNNING: begin
        if (emergency_stop) begin
          state_d = S_ERROR;
          err_d   = 2'd1;
        end else if (conveyor_jam) begin
          state_d = S_ERROR;
          err_d   = 2'd2;
        end else if (hopper_empty) begin
          state_d = S_PAUSED;
        end else if (pill_p) begin
          if (pill_inc == pill_tgt_q) begin
            pill_cnt_d = '0;
            bot_cnt_d  = bot_inc;
            if (bot_inc == bot_tgt_q) state_d = S_DONE;
          end else begin
            pill_cnt_d = pill_inc;
          end
        end
      end
      S_PAUSED: begin
        if (emergency_stop) begin
          state_d = S_ERROR;
          err_d   = 2'd1;
        end else if (conveyor_jam) begin
          state_d = S_ERROR;
          err_d   = 2'd2;
        end else if (!hopper_empty) begin
          state_d = S_RUNNING;
        end
      end
      S_DONE: begin
        if (emergency_stop) begin
          state_d = S_ERROR;
          err_d   = 2'd1;
        end else if (start_p) begin
          state_d    = S_SETTING;
          pill_cnt_d = '0;
          bot_cnt_d  = '0;
        end
      end
      S_ERROR: begin
        if (start_p && !emergency_stop && !conveyor_jam) begin
          state_d    = S_SETTING;
          err_d      = 2'd0;
          pill_cnt_d = '0;
          bot_cnt_d  = '0;
        end
      end
      default: state_d = S_SETTING;
    endcase
  end

  always_comb begin
    if (state_q == S_SETTING) begin
      disp = {bot_tgt_q, pill_tgt_q};
      if (!div_q[BLINK_BIT])
        for (int i = 0; i < N; i++)
          if (cursor_q == CW'(i)) disp[i] = 4'hF;
    end else begin
      disp = {bot_cnt_q, pill_cnt_q};
      if (state_q == S_ERROR && !div_q[BLINK_BIT]) disp = '1;
    end
  end

  always_comb begin
    case (state_q)
      S_DONE:   beep = div_q[BEEP_BIT];
      S_ERROR:  beep = div_q[BLINK_BIT];
      S_PAUSED: beep = div_q[BEEP_BIT] & div_q[BLINK_BIT];
      default:  beep = 1'b0;
    endcase
  end

  assign digit_out = disp;
  assign state_out = state_q;
  assign err_code  = err_q;

endmodule

// File: tb/tb_bottling_ctrl_param.sv
// Directed bench for bottling_ctrl_param with default parameters (3 pill digits, 2 bottle digits).
module tb_bottling_ctrl_param;

  logic        clk_1khz = 1'b0;
  logic        switch_clr, btn_next, btn_inc, btn_start, pill_pulse;
  logic        emergency_stop, hopper_empty, conveyor_jam;
  logic [19:0] digit_out;
  logic [2:0]  state_out;
  logic [1:0]  err_code;
  logic        beep;
  logic [8:0]  div_m;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk_1khz = ~clk_1khz;

  // Reference free-running divider, cleared by switch_clr
  always @(posedge clk_1khz) begin
    if (switch_clr) div_m <= '0;
    else            div_m <= div_m + 9'd1;
  end

  bottling_ctrl_param dut (
    .clk_1khz       (clk_1khz),
    .switch_clr     (switch_clr),
    .btn_next       (btn_next),
    .btn_inc        (btn_inc),
    .btn_start      (btn_start),
    .pill_pulse     (pill_pulse),
    .emergency_stop (emergency_stop),
    .hopper_empty   (hopper_empty),
    .conveyor_jam   (conveyor_jam),
    .digit_out      (digit_out),
    .state_out      (state_out),
    .err_code       (err_code),
    .beep           (beep)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_1khz);
    #1;
  endtask

  // which: 0 next, 1 inc, 2 start, 3 pill
  task automatic press(input int which);
    case (which)
      0: btn_next   = 1'b1;
      1: btn_inc    = 1'b1;
      2: btn_start  = 1'b1;
      default: pill_pulse = 1'b1;
    endcase
    tick(1);
    btn_next = 1'b0; btn_inc = 1'b0; btn_start = 1'b0; pill_pulse = 1'b0;
    tick(1);
  endtask

  task automatic presses(input int which, input int n);
    repeat (n) press(which);
  endtask

  task automatic wait_div(input int b, input logic v);
    for (int i = 0; i < 600 && div_m[b] !== v; i++) tick(1);
  endtask

  initial begin
    switch_clr = 1'b1; btn_next = 1'b0; btn_inc = 1'b0; btn_start = 1'b1;
    pill_pulse = 1'b0; emergency_stop = 1'b0; hopper_empty = 1'b0; conveyor_jam = 1'b0;
    tick(3);
    switch_clr = 1'b0;
    tick(2);
    // start held through reset must not start
    check_eq("rst_state", state_out, 3'd0);
    check_eq("rst_err",   err_code,  2'd0);
    check_eq("rst_beep",  beep,      1'b0);
    wait_div(7, 1'b0);
    check_eq("rst_disp_blank", digit_out, 20'h0100F);
    wait_div(7, 1'b1);
    check_eq("rst_disp", digit_out, 20'h01001);
    btn_start = 1'b0;
    tick(1);

    // targets 003 / 02, cursor back to 0
    presses(1, 2); presses(0, 3); presses(1, 1); presses(0, 2);
    wait_div(7, 1'b1);
    check_eq("set_tgt", digit_out, 20'h02003);
    wait_div(7, 1'b0);
    check_eq("cur0_blank", digit_out, 20'h0200F);
    presses(0, 5);
    wait_div(7, 1'b0);
    check_eq("next_wrap", digit_out, 20'h0200F);
    presses(0, 1);
    wait_div(7, 1'b0);
    check_eq("cur1_blank", digit_out, 20'h020F3);
    presses(1, 10); presses(0, 4);
    wait_div(7, 1'b1);
    check_eq("inc_wrap", digit_out, 20'h02003);

    // count to completion
    press(2);
    check_eq("run_state", state_out, 3'd1);
    check_eq("run_disp0", digit_out, 20'h00000);
    press(3);
    check_eq("pill1", digit_out, 20'h00001);
    presses(3, 2);
    check_eq("pill3", digit_out, 20'h01000);
    check_eq("pill3_state", state_out, 3'd1);
    presses(3, 2);
    check_eq("pill5", digit_out, 20'h01002);
    press(3);
    check_eq("done_state", state_out, 3'd3);
    check_eq("done_disp", digit_out, 20'h02000);
    wait_div(8, 1'b1);
    check_eq("done_beep_hi", beep, 1'b1);
    wait_div(8, 1'b0);
    check_eq("done_beep_lo", beep, 1'b0);
    press(2);
    check_eq("done_ack", state_out, 3'd0);
    wait_div(7, 1'b1);
    check_eq("tgt_kept", digit_out, 20'h02003);

    // zero pill target rejected
    presses(1, 7);
    wait_div(7, 1'b1);
    check_eq("zero_tgt", digit_out, 20'h02000);
    press(2);
    check_eq("zero_reject", state_out, 3'd0);
    presses(1, 3);

    // pause
    press(2);
    check_eq("restart", state_out, 3'd1);
    check_eq("cnt_cleared", digit_out, 20'h00000);
    presses(3, 2);
    check_eq("pause_pre", digit_out, 20'h00002);
    hopper_empty = 1'b1;
    presses(3, 4);
    check_eq("paused_state", state_out, 3'd2);
    check_eq("paused_cnt", digit_out, 20'h00002);
    wait_div(8, 1'b1);
    wait_div(7, 1'b1);
    check_eq("paused_beep_hi", beep, 1'b1);
    wait_div(8, 1'b0);
    check_eq("paused_beep_lo", beep, 1'b0);
    hopper_empty = 1'b0;
    tick(1);
    check_eq("resume", state_out, 3'd1);
    press(3);
    check_eq("resume_pill", digit_out, 20'h01000);

    // conveyor jam
    press(3);
    conveyor_jam = 1'b1;
    tick(1);
    check_eq("jam_state", state_out, 3'd4);
    check_eq("jam_err",   err_code,  2'd2);
    presses(3, 2);
    wait_div(7, 1'b1);
    check_eq("jam_frozen", digit_out, 20'h01001);
    check_eq("err_beep_hi", beep, 1'b1);
    wait_div(7, 1'b0);
    check_eq("err_blank", digit_out, 20'hFFFFF);
    check_eq("err_beep_lo", beep, 1'b0);
    press(2);
    check_eq("jam_ack_ignored", state_out, 3'd4);
    conveyor_jam = 1'b0;
    press(2);
    check_eq("jam_ack", state_out, 3'd0);
    check_eq("jam_err_clr", err_code, 2'd0);
    wait_div(7, 1'b1);
    check_eq("jam_tgt_kept", digit_out, 20'h02003);

    // emergency stop with simultaneous pill edge
    press(2);
    emergency_stop = 1'b1; pill_pulse = 1'b1;
    tick(1);
    pill_pulse = 1'b0;
    check_eq("estop_state", state_out, 3'd4);
    check_eq("estop_err",   err_code,  2'd1);
    press(2);
    check_eq("estop_held", state_out, 3'd4);
    emergency_stop = 1'b0;
    wait_div(7, 1'b1);
    check_eq("estop_no_pill", digit_out, 20'h00000);
    press(2);
    check_eq("estop_ack", state_out, 3'd0);

    // faults ignored in SETTING; clear overrides ERROR
    emergency_stop = 1'b1;
    tick(2);
    check_eq("set_ignores_estop", state_out, 3'd0);
    press(2);
    check_eq("estop_from_run", err_code, 2'd1);
    switch_clr = 1'b1;
    tick(1);
    check_eq("clr_state", state_out, 3'd0);
    check_eq("clr_err",   err_code,  2'd0);
    check_eq("clr_disp",  digit_out, 20'h0100F);
    switch_clr = 1'b0; emergency_stop = 1'b0;
    tick(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
